// File: rtl/sr_cmd_seq.sv
// Command sequencer for an SR flip-flop: queues set/clear/toggle commands and
// replays them as mutually exclusive, fixed-width s/r pulses separated by an idle gap.
module sr_cmd_seq #(
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned GAP_W   = 1,
    parameter int unsigned DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_i,
    output logic       cmd_ready_o,
    input  logic       q_i,
    output logic       s_o,
    output logic       r_o,
    output logic       done_o,
    output logic       busy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = 8;

    localparam logic [1:0] CMD_SET = 2'b01;
    localparam logic [1:0] CMD_CLR = 2'b10;
    localparam logic [1:0] CMD_TOG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]         mem_q [DEPTH];
    logic [1:0]         mem_d [DEPTH];

    logic               push;
    logic               pop;
    logic [1:0]         head;
    logic               set_sel;
    logic               clr_sel;

    assign cmd_ready_o = (count_q < CNT_W'(DEPTH)) && !reset;
    assign push        = cmd_valid_i && cmd_ready_o;
    assign busy_o      = (state_q != ST_IDLE) || (count_q != '0);
    assign s_o         = s_q;
    assign r_o         = r_q;
    assign done_o      = done_q;

    // Sequencer FSM plus FIFO pointer/count bookkeeping
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        s_d      = 1'b0;
        r_d      = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
        head     = mem_q[rd_ptr_q];
        set_sel  = 1'b0;
        clr_sel  = 1'b0;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    // Toggle resolves against q_i exactly at the pop edge
                    set_sel = (head == CMD_SET) || ((head == CMD_TOG) && !q_i);
                    clr_sel = (head == CMD_CLR) || ((head == CMD_TOG) && q_i);
                    if (set_sel || clr_sel) begin
                        state_d = ST_PULSE;
                        tmr_d   = '0;
                        s_d     = set_sel;
                        r_d     = clr_sel;
                        done_d  = (PULSE_W == 1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_q == TMR_W'(PULSE_W - 1)) begin
                    state_d = ST_GAP;
                    tmr_d   = '0;
                end else begin
                    tmr_d  = tmr_q + TMR_W'(1);
                    s_d    = s_q;
                    r_d    = r_q;
                    done_d = (tmr_q == TMR_W'(PULSE_W - 2));
                end
            end
            ST_GAP: begin
                if (tmr_q == TMR_W'(GAP_W - 1)) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = cmd_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count/pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Self-checking bench for sr_cmd_seq: three instances with different timing
// parameters, each looped through a behavioural SR flip-flop.
module tb_sr_cmd_seq;

    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_SET = 2'b01;
    localparam logic [1:0] C_CLR = 2'b10;
    localparam logic [1:0] C_TOG = 2'b11;

    logic       clk;
    logic [2:0] rst;
    logic       cmd_valid;
    logic [1:0] cmd_i;
    logic [2:0] rdy, s, r, dn, bz, q;
    logic       ff_init;

    int  sel;
    bit  mon_en;
    int  n_checks;
    int  n_pass;
    int  exp_q[$];
    bit  q_pred;
    int  done_cnt;
    int  pw_of [3] = '{2, 4, 3};

    bit  in_pulse;
    int  plen;
    int  ptype;
    bit  last_done;
    bit  early_done;

    sr_cmd_seq #(.PULSE_W(2), .GAP_W(1), .DEPTH(4)) u0 (
        .clk(clk), .reset(rst[0]), .cmd_valid_i(cmd_valid), .cmd_i(cmd_i),
        .cmd_ready_o(rdy[0]), .q_i(q[0]), .s_o(s[0]), .r_o(r[0]),
        .done_o(dn[0]), .busy_o(bz[0]));

    sr_cmd_seq #(.PULSE_W(4), .GAP_W(1), .DEPTH(4)) u1 (
        .clk(clk), .reset(rst[1]), .cmd_valid_i(cmd_valid), .cmd_i(cmd_i),
        .cmd_ready_o(rdy[1]), .q_i(q[1]), .s_o(s[1]), .r_o(r[1]),
        .done_o(dn[1]), .busy_o(bz[1]));

    sr_cmd_seq #(.PULSE_W(3), .GAP_W(2), .DEPTH(4)) u2 (
        .clk(clk), .reset(rst[2]), .cmd_valid_i(cmd_valid), .cmd_i(cmd_i),
        .cmd_ready_o(rdy[2]), .q_i(q[2]), .s_o(s[2]), .r_o(r[2]),
        .done_o(dn[2]), .busy_o(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SR flip-flops closing the feedback loop
    always @(posedge clk) begin
        if (ff_init) q <= '0;
        else begin
            for (int i = 0; i < 3; i++) begin
                if (s[i])      q[i] <= 1'b1;
                else if (r[i]) q[i] <= 1'b0;
            end
        end
    end

    // Expected pulse kind (0 none, 1 set, 2 clear); tracks the predicted FF state
    function automatic int next_kind(input logic [1:0] c);
        int k;
        case (c)
            C_SET:   k = 1;
            C_CLR:   k = 2;
            C_TOG:   k = q_pred ? 2 : 1;
            default: k = 0;
        endcase
        if (k == 1) q_pred = 1'b1;
        if (k == 2) q_pred = 1'b0;
        return k;
    endfunction

    // Scoreboard monitor: each completed pulse or NOP strobe pops one expectation
    always @(negedge clk) begin
        if (mon_en) begin
            int e;
            n_checks++;
            if (s[sel] && r[sel]) $display("FAIL excl: s_o=1 r_o=1 at %0t, required not both", $time);
            else n_pass++;
            if (s[sel] || r[sel]) begin
                if (!in_pulse) begin
                    in_pulse   = 1'b1;
                    plen       = 0;
                    ptype      = s[sel] ? 1 : 2;
                    early_done = 1'b0;
                end
                plen++;
                if (dn[sel] && plen < pw_of[sel]) early_done = 1'b1;
                last_done = dn[sel];
            end else begin
                if (in_pulse) begin
                    in_pulse = 1'b0;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    n_checks++;
                    if (ptype !== e) $display("FAIL pulse_kind: got %0d required %0d at %0t", ptype, e, $time);
                    else n_pass++;
                    n_checks++;
                    if (plen !== pw_of[sel]) $display("FAIL pulse_width: got %0d required %0d at %0t", plen, pw_of[sel], $time);
                    else n_pass++;
                    n_checks++;
                    if (!last_done || early_done)
                        $display("FAIL pulse_done: last=%0b early=%0b required last=1 early=0 at %0t", last_done, early_done, $time);
                    else n_pass++;
                end
                if (dn[sel]) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    n_checks++;
                    if (e !== 0) $display("FAIL nop_done: strobe without pulse, expected kind %0d required 0 at %0t", e, $time);
                    else n_pass++;
                end
            end
            if (dn[sel]) done_cnt++;
        end
    end

    task automatic push(input logic [1:0] c);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_i     = c;
        while (rdy[sel] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 300) $display("FAIL push_timeout: cmd_ready_o=%b required 1", rdy[sel]);
        else begin
            n_pass++;
            exp_q.push_back(next_kind(c));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(output bit timed_out);
        int n;
        n = 0;
        while ((bz[sel] || s[sel] || r[sel]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 300);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        sel       = 0;
        rst[0]    = 1'b1;
        cmd_valid = 1'b1;
        cmd_i     = C_SET;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({rdy[0], s[0], r[0], dn[0], bz[0]} !== 5'b0)
                $display("FAIL reset_outs: ready,s,r,done,busy=%b required 00000", {rdy[0], s[0], r[0], dn[0], bz[0]});
            else n_pass++;
        end
        cmd_valid = 1'b0;
        rst[0]    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdy[0] !== 1'b1) $display("FAIL reset_ready: cmd_ready_o=%b required 1", rdy[0]);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s[0], r[0], dn[0], bz[0]} !== 4'b0)
            $display("FAIL reset_empty: s,r,done,busy=%b required 0000", {s[0], r[0], dn[0], bz[0]});
        else n_pass++;
    endtask

    task automatic test_set_clr();
        logic [8:1] es, er, ed;
        bit to;
        es = 8'b0000_0011;
        er = 8'b0011_0000;
        ed = 8'b0010_0010;
        sel    = 0;
        q_pred = q[0];
        mon_en = 1'b1;
        cmd_valid = 1'b1;
        cmd_i     = C_SET;
        n_checks++;
        if (rdy[0] !== 1'b1) $display("FAIL sc_ready0: cmd_ready_o=%b required 1", rdy[0]);
        else n_pass++;
        exp_q.push_back(next_kind(C_SET));
        @(negedge clk);
        cmd_i = C_CLR;
        n_checks++;
        if (rdy[0] !== 1'b1) $display("FAIL sc_ready1: cmd_ready_o=%b required 1", rdy[0]);
        else n_pass++;
        exp_q.push_back(next_kind(C_CLR));
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if ({s[0], r[0], dn[0]} !== {es[k], er[k], ed[k]})
                $display("FAIL sc_cycle%0d: s,r,done=%b required %b", k, {s[0], r[0], dn[0]}, {es[k], er[k], ed[k]});
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (q[0] !== 1'b0) $display("FAIL sc_q: q=%b required 0", q[0]);
        else n_pass++;
        drain(to);
        n_checks++;
        if (to || exp_q.size() != 0) $display("FAIL sc_drain: timeout=%0b left=%0d required 0/0", to, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_toggle();
        bit to;
        sel    = 0;
        q_pred = q[0];
        repeat (3) push(C_TOG);
        drain(to);
        n_checks++;
        if (to || exp_q.size() != 0) $display("FAIL tog_drain: timeout=%0b left=%0d required 0/0", to, exp_q.size());
        else n_pass++;
        n_checks++;
        if (q[0] !== 1'b1) $display("FAIL tog_q: q=%b required 1", q[0]);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [1:0] cmds [6];
        int idx, acc_before_drop, low_cycles, d0;
        bit to;
        cmds = '{C_SET, C_CLR, C_TOG, C_NOP, C_SET, C_TOG};
        mon_en = 1'b0;
        rst[0] = 1'b1;
        rst[1] = 1'b0;
        sel    = 1;
        @(negedge clk);
        q_pred = q[1];
        mon_en = 1'b1;
        d0 = done_cnt;
        idx = 0;
        acc_before_drop = -1;
        low_cycles = 0;
        cmd_valid = 1'b1;
        cmd_i     = cmds[0];
        for (int cy = 0; cy < 100 && idx < 6; cy++) begin
            if (rdy[1]) begin
                exp_q.push_back(next_kind(cmds[idx]));
                idx++;
            end else begin
                if (acc_before_drop < 0) acc_before_drop = idx;
                low_cycles++;
            end
            @(negedge clk);
            if (idx < 6) cmd_i = cmds[idx];
            else cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (idx !== 6) $display("FAIL full_accepts: got %0d required 6", idx);
        else n_pass++;
        n_checks++;
        if (acc_before_drop !== 5) $display("FAIL full_drop: ready dropped after %0d accepts required 5", acc_before_drop);
        else n_pass++;
        n_checks++;
        if (low_cycles !== 3) $display("FAIL full_low: ready low %0d cycles required 3", low_cycles);
        else n_pass++;
        drain(to);
        n_checks++;
        if (to || exp_q.size() != 0) $display("FAIL full_drain: timeout=%0b left=%0d required 0/0", to, exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 6) $display("FAIL full_done: got %0d strobes required 6", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        bit any;
        mon_en = 1'b0;
        rst[1] = 1'b1;
        rst[2] = 1'b0;
        sel    = 2;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_i     = C_SET;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if ({s[2], r[2], dn[2], bz[2]} !== 4'b1001)
            $display("FAIL rmp_pulse: s,r,done,busy=%b required 1001", {s[2], r[2], dn[2], bz[2]});
        else n_pass++;
        rst[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({s[2], r[2], dn[2], rdy[2]} !== 4'b0)
            $display("FAIL rmp_drop: s,r,done,ready=%b required 0000", {s[2], r[2], dn[2], rdy[2]});
        else n_pass++;
        rst[2] = 1'b0;
        any = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (s[2] || r[2] || dn[2] || bz[2]) any = 1'b1;
        end
        n_checks++;
        if (any) $display("FAIL rmp_flush: activity after reset=%0b required 0", any);
        else n_pass++;
    endtask

    task automatic test_random();
        int acc, d0;
        bit took, to;
        mon_en = 1'b0;
        rst[2] = 1'b1;
        rst[0] = 1'b0;
        sel    = 0;
        @(negedge clk);
        q_pred = q[0];
        mon_en = 1'b1;
        d0  = done_cnt;
        acc = 0;
        cmd_valid = 1'b0;
        for (int cy = 0; cy < 500; cy++) begin
            if (!cmd_valid) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_i     = 2'($urandom_range(0, 3));
            end
            took = cmd_valid && rdy[0];
            if (took) begin
                exp_q.push_back(next_kind(cmd_i));
                acc++;
            end
            @(negedge clk);
            if (took) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        drain(to);
        n_checks++;
        if (to || exp_q.size() != 0) $display("FAIL rnd_drain: timeout=%0b left=%0d required 0/0", to, exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== acc) $display("FAIL rnd_done: got %0d strobes required %0d", done_cnt - d0, acc);
        else n_pass++;
        mon_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        done_cnt  = 0;
        in_pulse  = 1'b0;
        plen      = 0;
        ptype     = 0;
        last_done = 1'b0;
        early_done = 1'b0;
        mon_en    = 1'b0;
        sel       = 0;
        q_pred    = 1'b0;
        rst       = 3'b111;
        ff_init   = 1'b1;
        cmd_valid = 1'b0;
        cmd_i     = C_NOP;
        repeat (2) @(negedge clk);
        ff_init = 1'b0;
        test_reset();
        test_set_clr();
        test_toggle();
        test_fifo_full();
        test_reset_mid_pulse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
